hazard_ctrl_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core, replacing the single-cause load-use detector. It detects load-use hazards with register-zero exclusion and per-operand use qualification, and it stalls the front end for a parametrised multi-cycle multiply/divide unit (MDU) in EX using a small state machine. It also flushes IF/ID on taken branches and keeps a saturating stall-cycle performance counter. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and EX/MEM register controls.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_unit_mdu_fsm.sv | 62 ++++++
 rtl/hazard_ctrl_unit.sv | 89 ++++++++
 tb/tb_hazard_ctrl_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic pc_load;
      logic if_id_load;
      logic if_id_flush;
      logic id_ex_load;
      logic sel_signal;
      logic ex_mem_bubble;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_DEFAULT = '{pc_load: 1'b1, if_id_load: 1'b1, if_id_flush: 1'b0,
                                         id_ex_load: 1'b1, sel_signal: 1'b1, ex_mem_bubble: 1'b0};

endpackage

// File: rtl/hazard_ctrl_unit_mdu_fsm.sv
// Tracks a multi-cycle MDU op in EX: stalls the front end until the final cycle, then pulses done.
module mdu_stall_fsm
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic mdu_start,
   output logic mdu_stall,
   output logic mdu_done
);

   // cnt must hold MDU_LAT-2, the number of BUSY cycles before the done cycle
   localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 2);

   mdu_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (mdu_start) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
         end
         BUSY: begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mdu_stall = 1'b0;
      mdu_done  = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: mdu_stall = mdu_start;
            BUSY: begin
               mdu_stall = (cnt_q != '0);
               mdu_done  = (cnt_q == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: MDU stall, load-use bubble and taken-branch flush, plus a stall-cycle counter.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MDU_LAT    = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  branch_taken,
   input  logic                  mdu_start,
   input  logic                  perf_clr,
   output logic                  pc_load,
   output logic                  if_id_load,
   output logic                  if_id_flush,
   output logic                  id_ex_load,
   output logic                  sel_signal,
   output logic                  ex_mem_bubble,
   output logic                  mdu_done,
   output logic [CNT_W-1:0]      stall_cycles
);

   logic       load_use;
   logic       mdu_stall;
   hz_ctrl_t   ctrl;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   mdu_stall_fsm #(.MDU_LAT(MDU_LAT)) u_mdu_fsm (
      .clk       (clk),
      .rst       (rst),
      .mdu_start (mdu_start),
      .mdu_stall (mdu_stall),
      .mdu_done  (mdu_done)
   );

   always_comb begin
      load_use = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                 (((ex_rt == id_rs) && id_uses_rs) || ((ex_rt == id_rt) && id_uses_rt));
   end

   // A flush is only raised when IF/ID actually loads; a stalled branch re-resolves later.
   always_comb begin
      ctrl = CTRL_DEFAULT;
      if (rst) begin
         ctrl = CTRL_DEFAULT;
      end else if (mdu_stall) begin
         ctrl.pc_load       = 1'b0;
         ctrl.if_id_load    = 1'b0;
         ctrl.id_ex_load    = 1'b0;
         ctrl.ex_mem_bubble = 1'b1;
      end else if (load_use) begin
         ctrl.pc_load    = 1'b0;
         ctrl.if_id_load = 1'b0;
         ctrl.sel_signal = 1'b0;
      end else if (branch_taken) begin
         ctrl.if_id_flush = 1'b1;
      end
   end

   assign pc_load       = ctrl.pc_load;
   assign if_id_load    = ctrl.if_id_load;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_load    = ctrl.id_ex_load;
   assign sel_signal    = ctrl.sel_signal;
   assign ex_mem_bubble = ctrl.ex_mem_bubble;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (perf_clr)
         stall_cnt_d = '0;
      else if (!ctrl.pc_load && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; a second instance with a 2-bit counter checks saturation.
module tb_hazard_ctrl_unit;

   // Bundle order: {pc_load, if_id_load, if_id_flush, id_ex_load, sel_signal, ex_mem_bubble, mdu_done}
   localparam logic [6:0] C_DEF  = 7'b1101100;
   localparam logic [6:0] C_LU   = 7'b0001000;
   localparam logic [6:0] C_MDU  = 7'b0000110;
   localparam logic [6:0] C_DONE = 7'b1101101;
   localparam logic [6:0] C_BR   = 7'b1111100;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, mdu_start, perf_clr;
   logic pc_load, if_id_load, if_id_flush, id_ex_load, sel_signal, ex_mem_bubble, mdu_done;
   logic [15:0] stall_cycles;
   logic s_pc, s_ifid, s_fl, s_idex, s_sel, s_bub, s_done;
   logic [1:0] sat_cycles;
   logic [6:0] ctl;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_load, if_id_load, if_id_flush, id_ex_load, sel_signal, ex_mem_bubble, mdu_done};

   hazard_ctrl_unit #(.REG_ADDR_W(5), .MDU_LAT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .mdu_start(mdu_start), .perf_clr(perf_clr),
      .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
      .id_ex_load(id_ex_load), .sel_signal(sel_signal), .ex_mem_bubble(ex_mem_bubble),
      .mdu_done(mdu_done), .stall_cycles(stall_cycles)
   );

   hazard_ctrl_unit #(.REG_ADDR_W(5), .MDU_LAT(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .mdu_start(mdu_start), .perf_clr(perf_clr),
      .pc_load(s_pc), .if_id_load(s_ifid), .if_id_flush(s_fl),
      .id_ex_load(s_idex), .sel_signal(s_sel), .ex_mem_bubble(s_bub),
      .mdu_done(s_done), .stall_cycles(sat_cycles)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      branch_taken = 1'b0; mdu_start = 1'b0; perf_clr = 1'b0;
   endtask

   task automatic clear_perf();
      perf_clr = 1'b1;
      cyc();
      perf_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      // hazards present during reset must not show on the outputs
      mdu_start = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      branch_taken = 1'b1;
      cyc(); cyc();
      n_vec++;
      if (ctl !== C_DEF) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_DEF); end
      n_vec++;
      if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
      idle_inputs();
      rst = 1'b0;
      #1;
      n_vec++;
      if (ctl !== C_DEF) begin n_err++; $display("FAIL post_reset_idle got %b want %b", ctl, C_DEF); end
   endtask

   task automatic test_load_use();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_LU) begin n_err++; $display("FAIL load_use_ctl got %b want %b", ctl, C_LU); end
      cyc();
      idle_inputs();
      #1;
      n_vec++;
      if (ctl !== C_DEF) begin n_err++; $display("FAIL load_use_release got %b want %b", ctl, C_DEF); end
      n_vec++;
      if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL load_use_cnt got %0d want 1", stall_cycles); end
   endtask

   task automatic test_exclusions();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_DEF) begin n_err++; $display("FAIL reg_zero got %b want %b", ctl, C_DEF); end
      id_uses_rs = 1'b0; id_rs = 5'd3; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
      #1;
      n_vec++;
      if (ctl !== C_DEF) begin n_err++; $display("FAIL unused_rt got %b want %b", ctl, C_DEF); end
      id_uses_rt = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_LU) begin n_err++; $display("FAIL used_rt got %b want %b", ctl, C_LU); end
      idle_inputs();
      cyc();
   endtask

   task automatic test_mdu();
      logic [6:0] exp_seq [5] = '{C_MDU, C_MDU, C_MDU, C_DONE, C_DEF};
      clear_perf();
      for (int i = 0; i < 5; i++) begin
         mdu_start = (i < 4);
         #1;
         n_vec++;
         if (ctl !== exp_seq[i]) begin
            n_err++; $display("FAIL mdu_cycle%0d got %b want %b", i, ctl, exp_seq[i]);
         end
         cyc();
      end
      n_vec++;
      if (stall_cycles !== 16'd3) begin n_err++; $display("FAIL mdu_cnt got %0d want 3", stall_cycles); end
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp_seq [9] = '{C_MDU, C_MDU, C_MDU, C_DONE, C_MDU, C_MDU, C_MDU, C_DONE, C_DEF};
      for (int i = 0; i < 9; i++) begin
         mdu_start = (i < 8);
         #1;
         n_vec++;
         if (ctl !== exp_seq[i]) begin
            n_err++; $display("FAIL b2b_cycle%0d got %b want %b", i, ctl, exp_seq[i]);
         end
         cyc();
      end
      idle_inputs();
   endtask

   task automatic test_branch();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; branch_taken = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_LU) begin n_err++; $display("FAIL branch_with_lu got %b want %b", ctl, C_LU); end
      cyc();
      ex_mem_read = 1'b0;
      #1;
      n_vec++;
      if (ctl !== C_BR) begin n_err++; $display("FAIL branch_alone got %b want %b", ctl, C_BR); end
      mdu_start = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_MDU) begin n_err++; $display("FAIL branch_with_mdu got %b want %b", ctl, C_MDU); end
      mdu_start = 1'b0;
      cyc();
      idle_inputs();
   endtask

   task automatic test_rst_abort();
      mdu_start = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_MDU) begin n_err++; $display("FAIL abort_start got %b want %b", ctl, C_MDU); end
      cyc();
      mdu_start = 1'b0;
      rst = 1'b1;
      #1;
      n_vec++;
      if (ctl !== C_DEF) begin n_err++; $display("FAIL abort_in_reset got %b want %b", ctl, C_DEF); end
      cyc();
      rst = 1'b0;
      n_vec++;
      if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL abort_cnt got %0d want 0", stall_cycles); end
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (ctl !== C_DEF) begin n_err++; $display("FAIL abort_idle%0d got %b want %b", i, ctl, C_DEF); end
         cyc();
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      clear_perf();
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_vec++;
         if (sat_cycles !== exp_sat[i]) begin
            n_err++; $display("FAIL sat_cnt%0d got %0d want %0d", i, sat_cycles, exp_sat[i]);
         end
      end
      n_vec++;
      if (stall_cycles !== 16'd5) begin n_err++; $display("FAIL wide_cnt got %0d want 5", stall_cycles); end
      perf_clr = 1'b1;
      cyc();
      n_vec++;
      if (sat_cycles !== 2'd0) begin n_err++; $display("FAIL clr_over_stall got %0d want 0", sat_cycles); end
      n_vec++;
      if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL clr_wide got %0d want 0", stall_cycles); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_exclusions();
      test_mdu();
      test_back_to_back();
      test_branch();
      test_rst_abort();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
